mips_cpu_bus_arbiter: RTL and testbench
=======================================

# mips_cpu_bus_arbiter

Arbiter and sequencer that shares the CPU's single Avalon-style memory bus between the instruction-fetch port (driven during the fetch state) and the data port (driven during exec1/exec2 for loads and stores). It accepts one request at a time and registers all bus outputs. It runs the bus transaction through to completion under `waitrequest`, then returns a one-cycle `done` strobe with read data to the requester that owns the transaction. When both ports request together, it alternates between them round-robin.

## Interface
Parameters:
- `ADDR_W`, default 32: bus and requester address width.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request; held high until `i_done`.
- `i_addr`  in  ADDR_W  fetch address; held stable while `i_req`.
- `i_done`  out  1  one-cycle completion strobe for the fetch port.
- `i_rdata`  out  32  fetched word; valid from `i_done` until the next fetch completes.
- `d_req`  in  1  data request; held high until `d_done`.
- `d_write`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  32  store data.
- `d_byteenable`  in  4  store/load lane enables.
- `d_done`  out  1  one-cycle completion strobe for the data port.
- `d_rdata`  out  32  load data; valid from `d_done` until the next data load completes.
- `address`  out  ADDR_W  bus address.
- `read`  out  1  bus read strobe.
- `write`  out  1  bus write strobe.
- `writedata`  out  32  bus write data.
- `byteenable`  out  4  bus lane enables.
- `waitrequest`  in  1  bus stall; a transfer completes on an edge where this is 0.
- `readdata`  in  32  bus read data; valid in the cycle `waitrequest` is 0.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: samples requests.
  - BUS_I: fetch transaction in progress.
  - BUS_D: data transaction in progress.
  - RESP: done strobe cycle; requests are ignored.
- IDLE transitions:
  - Neither request: stay in IDLE.
  - Only `i_req`: go to BUS_I.
  - Only `d_req`: go to BUS_D.
  - Both requests: grant the port that did not win the last arbitration, then update `last_grant`.
- Entry to BUS_I latches the following registers:
  - `address` = {`i_addr`[ADDR_W-1:2], 2'b00}.
  - `read` = 1, `write` = 0.
  - `byteenable` = 4'b1111.
- Entry to BUS_D latches the following registers:
  - `address` = `d_addr`.
  - `write` = `d_write`, `read` = !`d_write`.
  - `writedata` = `d_wdata`.
  - `byteenable` = `d_byteenable`.
- In BUS_I or BUS_D:
  - Bus outputs are held constant while `waitrequest` = 1; there is no timeout.
  - On an edge with `waitrequest` = 0: clear `read`/`write`, go to RESP, and assert the owner's `done` during RESP.
  - If the owner is a read, also capture `readdata` into `i_rdata` or `d_rdata` on that edge.
- RESP: always returns to IDLE on the next edge. A requester uses the `done` cycle to drop or replace its request, so IDLE sees fresh inputs.
- The non-owning port's `done` and `rdata` are never disturbed.
- A data store never modifies `d_rdata`.
- `writedata` keeps its last value when not writing.

## Timing
- Reset (asynchronous, `rst_n` = 0):
  - State goes to IDLE.
  - `read`, `write`, `i_done`, `d_done`, `busy` = 0.
  - `address`, `writedata`, `i_rdata`, `d_rdata` = 0; `byteenable` = 0.
  - `last_grant` = data, so fetch wins the first tie.
- Reset asserted mid-transaction drops the bus strobes immediately. No `done` is issued for the aborted transfer.
- Zero-wait transfer: `req` sampled at edge 0. `read`/`write` are high in cycle 1 and `waitrequest` = 0 in cycle 1. `done` is high in cycle 2. IDLE is reached in cycle 3.
- Latency from request to `done` = 2 + N cycles, where N is the number of `waitrequest`-high cycles.
- Minimum request-to-request spacing on one port is 3 cycles. Bus strobes are never asserted in IDLE or RESP.
- A request that arrives during BUS or RESP waits. It is arbitrated at the next IDLE.
- `busy` = 1 in BUS_I, BUS_D and RESP.

## Test plan
- Reset then a fetch (`i_req` = 1, `i_addr` = 0xBFC00003, `waitrequest` = 0, `readdata` = 0x24020005) -> `address` = 0xBFC00000, `read` = 1 and `byteenable` = 4'hF for one cycle. Then `i_done` pulses one cycle with `i_rdata` = 0x24020005, and `d_done` stays 0.
- Data store (`d_write` = 1, `d_addr` = 0x100, `d_wdata` = 0xDEADBEEF, `d_byteenable` = 4'b0011, `waitrequest` high for 3 cycles) -> `write` = 1 with fields stable for 4 cycles. Then `d_done` pulses and `d_rdata` is unchanged.
- Both ports requesting continuously from reset -> grant order is fetch, data, fetch, data. Each completion is followed by exactly one RESP cycle.
- Load with `waitrequest` = 1 for 5 cycles, then `readdata` = 0x12345678 -> `d_done` appears 7 cycles after the request with `d_rdata` = 0x12345678. Meanwhile `readdata` changing while stalled is not captured.
- `rst_n` pulsed low during BUS_D with `waitrequest` high -> `read`/`write` fall without waiting for a clock edge. No `done` is issued. After release the arbiter is in IDLE and fetch wins the next tie.

Source files
------------

// File: rtl/mips_cpu_bus_arbiter.sv
// Shares the CPU's single Avalon-style memory bus between the fetch and data ports.
// One transaction at a time; all bus outputs registered; round-robin on simultaneous requests.
module mips_cpu_bus_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_byteenable,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic              waitrequest,
  input  logic [31:0]       readdata,
  output logic              busy
);

  // state   | meaning
  // S_IDLE  | sample requests and arbitrate
  // S_BUS_I | fetch transfer on the bus
  // S_BUS_D | data transfer on the bus
  // S_RESP  | done strobe to the owner; requests ignored
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUS_I = 2'd1;
  localparam logic [1:0] S_BUS_D = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;  // 1 = data port won last
  logic [ADDR_W-1:0] address_q, address_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [31:0]       writedata_q, writedata_d;
  logic [3:0]        byteenable_q, byteenable_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              grant_i, grant_d;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        grant_i = i_req && (!d_req || last_grant_q);
        grant_d = d_req && !grant_i;
        if (grant_i) begin
          state_d      = S_BUS_I;
          last_grant_d = 1'b0;
          address_d    = i_addr & WORD_MASK;
          read_d       = 1'b1;
          write_d      = 1'b0;
          byteenable_d = 4'b1111;
        end else if (grant_d) begin
          state_d      = S_BUS_D;
          last_grant_d = 1'b1;
          address_d    = d_addr;
          read_d       = !d_write;
          write_d      = d_write;
          writedata_d  = d_wdata;
          byteenable_d = d_byteenable;
        end
      end
      S_BUS_I: begin
        if (!waitrequest) begin
          state_d   = S_RESP;
          read_d    = 1'b0;
          write_d   = 1'b0;
          i_done_d  = 1'b1;
          i_rdata_d = readdata;
        end
      end
      S_BUS_D: begin
        if (!waitrequest) begin
          state_d  = S_RESP;
          read_d   = 1'b0;
          write_d  = 1'b0;
          d_done_d = 1'b1;
          // stores leave the load-data register alone
          if (read_q) begin
            d_rdata_d = readdata;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign i_done     = i_done_q;
  assign d_done     = d_done_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Bench for mips_cpu_bus_arbiter: vector table driven through a bus model, with a
// completion scoreboard, plus hand sequences for round-robin ties and mid-transfer reset.
module tb_mips_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_write, waitrequest;
  logic [31:0] i_addr, d_addr, d_wdata, readdata;
  logic [3:0]  d_byteenable;
  logic        i_done, d_done, read, write, busy;
  logic [31:0] i_rdata, d_rdata, address, writedata;
  logic [3:0]  byteenable;

  always #5 clk = ~clk;

  mips_cpu_bus_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_done(d_done), .d_rdata(d_rdata),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
    .busy(busy)
  );

  typedef struct {
    bit          is_data;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          nwait;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    bit          exp_rd;
    bit          exp_wr;
    logic [3:0]  exp_be;
  } vec_t;

  typedef struct {
    bit          is_data;
    logic [31:0] addr;
    bit          rd;
    bit          wr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          exp_cyc;
    int          nwait;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sb[$];
  int          done_log[$];
  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;

  bit          in_xfer = 1'b0;
  int          strobe_cnt = 0;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_be;
  logic        snap_rd, snap_wr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus-side monitor: stability while stalled, strobe hygiene, completion scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!busy || i_done || d_done) chk("no_strobe_idle_resp", {30'd0, read, write}, 32'd0);
      if (read || write) begin
        if (in_xfer) begin
          chk("stable_addr", address, snap_addr);
          chk("stable_be", {28'd0, byteenable}, {28'd0, snap_be});
          chk("stable_rw", {30'd0, read, write}, {30'd0, snap_rd, snap_wr});
          if (snap_wr) chk("stable_wdata", writedata, snap_wdata);
        end else begin
          snap_addr  = address;
          snap_be    = byteenable;
          snap_rd    = read;
          snap_wr    = write;
          snap_wdata = writedata;
          in_xfer    = 1'b1;
          strobe_cnt = 0;
        end
        strobe_cnt++;
      end
      if (i_done || d_done) begin
        chk("busy_in_resp", {31'd0, busy}, 32'd1);
        done_log.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got i_done=%b d_done=%b expected none", i_done, d_done);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_port", {30'd0, i_done, d_done}, e.is_data ? 32'd1 : 32'd2);
          chk("bus_addr", snap_addr, e.addr);
          chk("bus_rw", {30'd0, snap_rd, snap_wr}, {30'd0, e.rd, e.wr});
          chk("bus_be", {28'd0, snap_be}, {28'd0, e.be});
          if (e.wr) chk("bus_wdata", snap_wdata, e.wdata);
          if (e.nwait >= 0) chk("strobe_cycles", strobe_cnt, e.nwait + 1);
          if (e.exp_cyc >= 0) chk("done_latency", cyc, e.exp_cyc);
          if (!e.is_data) exp_i_rdata = e.rdata;
          else if (!e.wr) exp_d_rdata = e.rdata;
          chk("i_rdata", i_rdata, exp_i_rdata);
          chk("d_rdata", d_rdata, exp_d_rdata);
        end
        in_xfer = 1'b0;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    exp_t e;
    e.is_data = v.is_data; e.addr = v.exp_addr; e.rd = v.exp_rd; e.wr = v.exp_wr;
    e.be = v.exp_be; e.wdata = v.wdata; e.rdata = v.rdata;
    e.exp_cyc = cyc + 2 + v.nwait; e.nwait = v.nwait;
    sb.push_back(e);
    waitrequest = (v.nwait > 0);
    readdata    = (v.nwait > 0) ? $urandom : v.rdata;
    if (v.is_data) begin
      d_req = 1'b1; d_write = v.wr; d_addr = v.addr; d_wdata = v.wdata; d_byteenable = v.be;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    @(posedge clk); #1;
    for (int k = 0; k < v.nwait; k++) begin
      waitrequest = 1'b1;
      readdata = $urandom;
      @(posedge clk); #1;
    end
    waitrequest = 1'b0;
    readdata = v.rdata;
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    readdata = $urandom;
    @(posedge clk); #1;
  endtask

  // Both ports request continuously; fetch must win first when last_grant is data.
  task automatic run_tie(input int n);
    exp_t e;
    bit   got;
    waitrequest = 1'b0; readdata = 32'hA5A5_1234;
    i_addr = 32'h0000_1002; d_addr = 32'h0000_2001; d_write = 1'b0; d_byteenable = 4'hF;
    for (int k = 0; k < n; k++) begin
      e.is_data = k[0]; e.addr = k[0] ? 32'h0000_2001 : 32'h0000_1000;
      e.rd = 1'b1; e.wr = 1'b0; e.be = 4'hF; e.wdata = '0; e.rdata = 32'hA5A5_1234;
      e.exp_cyc = -1; e.nwait = 0;
      sb.push_back(e);
    end
    done_log.delete();
    i_req = 1'b1; d_req = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(posedge clk); #1;
      if (done_log.size() >= n) got = 1'b1;
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("tie_done_count", done_log.size(), n);
    for (int k = 1; k < done_log.size(); k++)
      chk("tie_done_spacing", done_log[k] - done_log[k-1], 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{0, 0, 32'hBFC0_0003, 32'h0, 4'h0, 0, 32'h2402_0005, 32'hBFC0_0000, 1, 0, 4'hF};
    vecs[1] = '{1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 3, 32'h0, 32'h0000_0100, 0, 1, 4'b0011};
    vecs[2] = '{1, 0, 32'h0000_0204, 32'h0, 4'hF, 5, 32'h1234_5678, 32'h0000_0204, 1, 0, 4'hF};
    vecs[3] = '{0, 0, 32'h0040_0006, 32'h0, 4'h0, 1, 32'h8C88_0000, 32'h0040_0004, 1, 0, 4'hF};
    vecs[4] = '{1, 1, 32'h0000_0208, 32'hCAFE_F00D, 4'b1100, 0, 32'h0, 32'h0000_0208, 0, 1, 4'b1100};
    vecs[5] = '{1, 0, 32'h0000_020B, 32'h0, 4'b1000, 2, 32'h0000_00AB, 32'h0000_020B, 1, 0, 4'b1000};
    vecs[6] = '{0, 0, 32'hFFFF_FFFF, 32'h0, 4'h0, 0, 32'h03E0_0008, 32'hFFFF_FFFC, 1, 0, 4'hF};

    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_write = 1'b0; waitrequest = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_byteenable = '0; readdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_address", address, 32'h0);
    chk("rst_read", {31'd0, read}, 32'd0);
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_writedata", writedata, 32'h0);
    chk("rst_byteenable", {28'd0, byteenable}, 32'd0);
    chk("rst_i_done", {31'd0, i_done}, 32'd0);
    chk("rst_d_done", {31'd0, d_done}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    run_tie(4);

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Abort a stalled data load with reset; strobes must drop without a clock edge.
    waitrequest = 1'b1; readdata = 32'h5555_AAAA;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0000_0300; d_byteenable = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_read", {31'd0, read}, 32'd1);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_read", {31'd0, read}, 32'd0);
    chk("async_rst_write", {31'd0, write}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_d_done", {31'd0, d_done}, 32'd0);
    sb.delete();
    in_xfer = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    d_req = 1'b0;
    waitrequest = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    run_tie(2);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
